// File: rtl/seq_window_mon.sv
// seq_window_mon: per-channel monitor for "a, then b within MIN_DLY..MAX_DLY
// cycles". It supports overlapping attempts and first-match completion. Each
// channel has registered hit/miss pulses and saturating hit/miss counters.
// Optional feature macro: SEQMON_MISS_EN. When it is defined, the expire
// detection, the miss pulse and miss_cnt are built. When it is undefined,
// miss and miss_cnt are tied to 0 and expiring attempts simply age out.
module seq_window_mon #(
   parameter int NCH     = 4,
   parameter int MIN_DLY = 1,
   parameter int MAX_DLY = 5,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 clr,
   input  logic [NCH-1:0]       a,
   input  logic [NCH-1:0]       b,
   output logic [NCH-1:0]       hit,
   output logic [NCH-1:0]       miss,
   output logic [NCH-1:0]       busy,
   output logic [NCH*CNT_W-1:0] hit_cnt,
   output logic [NCH*CNT_W-1:0] miss_cnt
);

   // Ages MIN_DLY..MAX_DLY form the window in which b completes an attempt.
   function automatic logic [MAX_DLY:1] win_mask_f();
      logic [MAX_DLY:1] m;
      for (int k = 1; k <= MAX_DLY; k++) m[k] = (k >= MIN_DLY);
      return m;
   endfunction

   localparam logic [MAX_DLY:1] WIN = win_mask_f();

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
      return (inc && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      // pend[k] = 1: an attempt started exactly k edges ago.
      logic [MAX_DLY:1] pend;
      logic [MAX_DLY:1] pend_nxt;
      logic             match;
      logic             hit_r;
      logic [CNT_W-1:0] hcnt;

      // One b consumes every in-window attempt. Younger attempts keep aging.
      always_comb begin
         match    = b[g] & (|(pend & WIN));
         pend_nxt = '0;
         for (int k = 2; k <= MAX_DLY; k++)
            pend_nxt[k] = pend[k-1] & ~(match & WIN[k-1]);
         pend_nxt[1] = a[g] & en;
      end

      // Pending-attempt vector, hit pulse and saturating hit counter.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pend  <= '0;
            hit_r <= 1'b0;
            hcnt  <= '0;
         end else if (clr) begin
            pend  <= '0;
            hit_r <= 1'b0;
            hcnt  <= '0;
         end else begin
            pend  <= pend_nxt;
            hit_r <= match;
            hcnt  <= sat_inc(hcnt, match);
         end
      end

      assign hit[g]                      = hit_r;
      assign busy[g]                     = |pend;
      assign hit_cnt[g*CNT_W +: CNT_W]   = hcnt;

`ifdef SEQMON_MISS_EN
      logic             expire;
      logic             miss_r;
      logic [CNT_W-1:0] mcnt;

      // Oldest attempt leaves the window unanswered. A present b turns it into a hit.
      assign expire = pend[MAX_DLY] & ~b[g];

      // Miss pulse and saturating miss counter.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            miss_r <= 1'b0;
            mcnt   <= '0;
         end else if (clr) begin
            miss_r <= 1'b0;
            mcnt   <= '0;
         end else begin
            miss_r <= expire;
            mcnt   <= sat_inc(mcnt, expire);
         end
      end

      assign miss[g]                     = miss_r;
      assign miss_cnt[g*CNT_W +: CNT_W]  = mcnt;
`else
      assign miss[g]                     = 1'b0;
      assign miss_cnt[g*CNT_W +: CNT_W]  = '0;
`endif
   end

endmodule
